// File: rtl/seq_divider_8_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int WIDTH = 8;
  localparam logic [2:0] ITER_LAST = 3'd7;

endpackage

// File: rtl/seq_divider_8_reg.sv
// 8-bit left-shifting register used for the quotient; the MSB feeds the divider's partial remainder.
module reg_8_L (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic       Shift_En,
  input  logic       Shift_In,
  input  logic [7:0] D,
  output logic       Shift_Out,
  output logic [7:0] Data_Out
);

  always_ff @(posedge Clk) begin
    if (Reset)
      Data_Out <= 8'h00;
    else if (Load)
      Data_Out <= D;
    else if (Shift_En)
      Data_Out <= {Data_Out[6:0], Shift_In};
  end

  assign Shift_Out = Data_Out[7];

endmodule

// File: rtl/seq_divider_8.sv
// Sequential 8-bit unsigned restoring divider: one shift/trial-subtract iteration per clock.
module seq_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             LoadDvsr,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic [WIDTH-1:0] Dvsr_Val,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);
  import divider_pkg::*;

  state_t           state_reg;
  logic [2:0]       count_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic             dbz_reg;

  logic             q_msb;
  logic [WIDTH-1:0] q_val;
  logic             q_load;
  logic             q_shift;
  logic [WIDTH-1:0] q_d;

  logic [WIDTH:0]   p_val;
  logic [WIDTH:0]   t_val;
  logic             dvsr_zero;

  assign dvsr_zero = (dvsr_reg == '0);
  assign p_val     = {a_reg, q_msb};
  assign t_val     = p_val - {1'b0, dvsr_reg};

  always_comb begin
    q_load  = 1'b0;
    q_shift = 1'b0;
    q_d     = Din;
    case (state_reg)
      IDLE: begin
        if (!LoadDvsr && Run) begin
          q_load = 1'b1;
          // A zero divisor reports an all-ones quotient with the dividend as remainder.
          q_d    = dvsr_zero ? '1 : Din;
        end
      end
      CALC:    q_shift = 1'b1;
      default: ;
    endcase
  end

  reg_8_L u_q_reg (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (q_load),
    .Shift_En (q_shift),
    .Shift_In (~t_val[WIDTH]),
    .D        (q_d),
    .Shift_Out(q_msb),
    .Data_Out (q_val)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      count_reg <= 3'd0;
      a_reg     <= '0;
      dvsr_reg  <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (LoadDvsr) begin
            dvsr_reg <= Din;
          end else if (Run) begin
            if (!dvsr_zero) begin
              a_reg     <= '0;
              count_reg <= 3'd0;
              dbz_reg   <= 1'b0;
              state_reg <= CALC;
            end else begin
              a_reg     <= Din;
              dbz_reg   <= 1'b1;
              state_reg <= HOLD;
            end
          end
        end
        CALC: begin
          // Borrow set means the trial subtraction failed: restore the shifted value.
          a_reg     <= t_val[WIDTH] ? p_val[WIDTH-1:0] : t_val[WIDTH-1:0];
          count_reg <= count_reg + 3'd1;
          if (count_reg == ITER_LAST)
            state_reg <= HOLD;
        end
        HOLD: begin
          if (!Run)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Aval        = a_reg;
  assign Bval        = q_val;
  assign Dvsr_Val    = dvsr_reg;
  assign Busy        = (state_reg == CALC);
  assign Done        = (state_reg == HOLD);
  assign Div_By_Zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider_8.sv
// Self-checking bench for seq_divider_8 against an arithmetic quotient/remainder model.
module tb_seq_divider_8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       load_dvsr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] aval, bval, dvsr_val;
  logic       busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_8 #(.WIDTH(8)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .Run        (run),
    .LoadDvsr   (load_dvsr),
    .Din        (din),
    .Aval       (aval),
    .Bval       (bval),
    .Dvsr_Val   (dvsr_val),
    .Busy       (busy),
    .Done       (done),
    .Div_By_Zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_divisor(input logic [7:0] v);
    load_dvsr = 1'b1;
    din       = v;
    tick();
    load_dvsr = 1'b0;
  endtask

  // Starts a division (Run left high) and reports edges-to-Done, counting the start edge,
  // and how many post-edge samples showed Busy before Done. Optionally pokes LoadDvsr mid-run.
  task automatic start_division(input logic [7:0] dividend, input bit poke_load,
                                output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    run      = 1'b1;
    din      = dividend;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      din = 8'($urandom);
      if (poke_load && i == 2) load_dvsr = 1'b1;
      else load_dvsr = 1'b0;
      if (done) break;
      if (busy) busy_cnt++;
    end
    load_dvsr = 1'b0;
    if (!done) lat = -1;
  endtask

  task automatic release_run();
    run = 1'b0;
    tick();
  endtask

  task automatic check_result(input string name, input logic [7:0] dvsr, input logic [7:0] dividend,
                              input int lat, input int busy_cnt);
    logic [7:0] exp_q, exp_a;
    logic       exp_z;
    int         exp_lat, exp_busy;
    if (dvsr == 0) begin
      exp_q = 8'hFF; exp_a = dividend; exp_z = 1'b1; exp_lat = 1; exp_busy = 0;
    end else begin
      exp_q = 8'(int'(dividend) / int'(dvsr));
      exp_a = 8'(int'(dividend) % int'(dvsr));
      exp_z = 1'b0; exp_lat = 9; exp_busy = 8;
    end
    checks++;
    if (bval !== exp_q || aval !== exp_a || div_by_zero !== exp_z || lat != exp_lat ||
        busy_cnt != exp_busy || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s: %0d/%0d got Q=%h A=%h dbz=%b lat=%0d busy_cnt=%0d busy=%b done=%b, need Q=%h A=%h dbz=%b lat=%0d busy_cnt=%0d busy=0 done=1",
               name, dividend, dvsr, bval, aval, div_by_zero, lat, busy_cnt, busy, done,
               exp_q, exp_a, exp_z, exp_lat, exp_busy);
    end else begin
      $display("ok   %s: %0d/%0d -> Q=%0d A=%0d dbz=%b lat=%0d", name, dividend, dvsr, bval, aval,
               div_by_zero, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({aval, bval, dvsr_val, busy, done, div_by_zero} !== 27'd0) begin
      errors++;
      $display("FAIL reset: A=%h Q=%h D=%h busy=%b done=%b dbz=%b, need all 0",
               aval, bval, dvsr_val, busy, done, div_by_zero);
    end else $display("ok   reset: all outputs 0");
  endtask

  task automatic test_directed();
    logic [7:0] dv [5] = '{8'd7, 8'd1, 8'd255, 8'd200, 8'd0};
    logic [7:0] dd [5] = '{8'd100, 8'd255, 8'd255, 8'd5, 8'd200};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      load_divisor(dv[i]);
      start_division(dd[i], 1'b0, lat, bc);
      check_result("directed", dv[i], dd[i], lat, bc);
      release_run();
      checks++;
      if (done !== 1'b0 || bval !== ((dv[i] == 0) ? 8'hFF : 8'(int'(dd[i]) / int'(dv[i])))) begin
        errors++;
        $display("FAIL idle_hold: done=%b Q=%h after Run release", done, bval);
      end
    end
  endtask

  task automatic test_load_priority();
    load_dvsr = 1'b1;
    run       = 1'b1;
    din       = 8'd9;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dvsr_val !== 8'd9) begin
      errors++;
      $display("FAIL load_priority: busy=%b done=%b dvsr=%h, need 0 0 09", busy, done, dvsr_val);
    end else $display("ok   load_priority: dvsr=09, no start");
    load_dvsr = 1'b0;
    run       = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_calc();
    int lat, bc;
    load_divisor(8'd7);
    run = 1'b1;
    din = 8'd100;
    tick();
    tick(); tick(); tick();
    run   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({aval, bval, dvsr_val, busy, done, div_by_zero} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: A=%h Q=%h D=%h busy=%b done=%b dbz=%b, need all 0",
               aval, bval, dvsr_val, busy, done, div_by_zero);
    end else $display("ok   reset_mid_calc: all outputs 0");
    load_divisor(8'd11);
    start_division(8'd250, 1'b0, lat, bc);
    check_result("after_reset", 8'd11, 8'd250, lat, bc);
    release_run();
  endtask

  task automatic test_run_held();
    int lat, bc;
    load_divisor(8'd13);
    start_division(8'd200, 1'b0, lat, bc);
    check_result("run_held", 8'd13, 8'd200, lat, bc);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bval !== 8'd15 || aval !== 8'd5) begin
      errors++;
      $display("FAIL run_held: done=%b busy=%b Q=%h A=%h, need 1 0 0f 05", done, busy, bval, aval);
    end else $display("ok   run_held: result held, no restart");
    release_run();
    din = 8'd3;
    start_division(8'd77, 1'b1, lat, bc);
    check_result("reuse_dvsr", 8'd13, 8'd77, lat, bc);
    checks++;
    if (dvsr_val !== 8'd13) begin
      errors++;
      $display("FAIL load_in_calc: dvsr=%h, need 0d", dvsr_val);
    end else $display("ok   load_in_calc: dvsr unchanged 0d");
    release_run();
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] dv, dd;
    for (int n = 0; n < 1000; n++) begin
      dv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      dd = 8'($urandom);
      load_divisor(dv);
      start_division(dd, 1'b0, lat, bc);
      check_result("random", dv, dd, lat, bc);
      release_run();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_load_priority();
    test_reset_mid_calc();
    test_run_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
